// File: rtl/grid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : grid_arbiter
//  Description : Two-requester arbiter in front of grid memory port A.
//                Requester 0 is the piece logic, requester 1 is the
//                line-clear engine. Requests are sampled on one edge, the
//                winner drives the registered memory port the next cycle,
//                and read data comes back one cycle later as a pass-through
//                of mem_q. Round-robin between the two requesters, with
//                optional bus locking.
//  Options     : GRID_ARB_LOCK_EN -- when defined, lock0/lock1 let a
//                requester keep the port (OWN0/OWN1) for up to LOCK_MAX
//                cycles; lock_err pulses on a forced release. When not
//                defined the lock inputs are ignored and the arbiter is
//                pure round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              lock_err
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                prio_q;      // 1: requester 1 wins a tie
    logic                prio_d;
    logic                armed_q;     // blocks grants on the first edge after reset
    logic                w_win0;
    logic                w_win1;

    logic                gnt0_q;
    logic                gnt1_q;
    logic                rvalid0_q;
    logic                rvalid1_q;
    logic                rvalid0_d;
    logic                rvalid1_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                mem_we_q;
    logic                mem_we_d;

`ifdef GRID_ARB_LOCK_EN
    localparam int                  c_cnt_w    = $clog2(LOCK_MAX + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(LOCK_MAX - 1);

    logic [c_cnt_w-1:0]  cnt_q;
    logic [c_cnt_w-1:0]  cnt_d;
    logic                lock_err_q;
    logic                lock_err_d;
`else
    localparam int       c_unused_lock_max = LOCK_MAX;
    logic                w_unused_lock;
    assign w_unused_lock = lock0 ^ lock1;
`endif

    // Winner selection, round-robin pointer and ownership next-state
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        w_win0  = 1'b0;
        w_win1  = 1'b0;
`ifdef GRID_ARB_LOCK_EN
        cnt_d      = cnt_q;
        lock_err_d = 1'b0;
`endif
        if (armed_q) begin
            unique case (state_q)
                OWN0:    w_win0 = req0;
                OWN1:    w_win1 = req1;
                default: begin
                    w_win0 = req0 & (~req1 | ~prio_q);
                    w_win1 = req1 & ~w_win0;
                end
            endcase
        end

        // The pointer always favours the requester that was not just served.
        if (w_win0) begin
            prio_d = 1'b1;
        end else if (w_win1) begin
            prio_d = 1'b0;
        end

`ifdef GRID_ARB_LOCK_EN
        unique case (state_q)
            OWN0, OWN1: begin
                if ((state_q == OWN0) ? (w_win0 & ~lock0) : (w_win1 & ~lock1)) begin
                    // Owner released the port with its last access.
                    state_d = ARB;
                    cnt_d   = '0;
                end else if (cnt_q == c_cnt_last) begin
                    // Owner held too long: take the port back, favour the other side.
                    state_d    = ARB;
                    cnt_d      = '0;
                    lock_err_d = 1'b1;
                    prio_d     = (state_q == OWN0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                if (w_win0 & lock0) begin
                    state_d = OWN0;
                end else if (w_win1 & lock1) begin
                    state_d = OWN1;
                end
            end
        endcase
`endif
    end

    // Memory port drive: winner's request is registered, otherwise idle
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (w_win0) begin
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
            mem_we_d    = we0;
        end else if (w_win1) begin
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
            mem_we_d    = we1;
        end
        // A read issued this cycle returns its data on the next one.
        rvalid0_d = gnt0_q & ~mem_we_q;
        rvalid1_d = gnt1_q & ~mem_we_q;
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            prio_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            armed_q <= 1'b1;
        end
    end

`ifdef GRID_ARB_LOCK_EN
    // Ownership cycle counter and forced-release flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            lock_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_err = lock_err_q;
`else
    assign lock_err = 1'b0;
`endif

    // Grant, read-valid and memory port registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            gnt0_q      <= w_win0;
            gnt1_q      <= w_win1;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign rdata     = mem_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grid_arbiter
//  Description : Directed self-checking bench for grid_arbiter with a small
//                synchronous grid memory model on port A. Lock-dependent
//                expectations follow GRID_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_arbiter;

`ifdef GRID_ARB_LOCK_EN
    localparam bit c_lk = 1'b1;
`else
    localparam bit c_lk = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we, lock_err;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_q;

    logic [7:0] tb_mem [256];
    int         n_total;
    int         n_bad;

    grid_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .LOCK_MAX (16)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .lock0     (lock0),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .lock_err  (lock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grid memory port A: write on mem_we, registered read of mem_addr
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_q <= tb_mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    logic [4:0] seq_g0;
    logic [4:0] seq_g1;
    int         left0;

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int a = 0; a < 256; a++) tb_mem[a] = 8'h00;
        tb_mem[8'h12] = 8'hA5;
        tb_mem[8'h20] = 8'h5A;
        reset = 1'b0;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_gnt0", gnt0, 0);
        check_eq("rst_gnt1", gnt1, 0);
        check_eq("rst_rvalid0", rvalid0, 0);
        check_eq("rst_rvalid1", rvalid1, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_lock_err", lock_err, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);

        // Single read, request already pending at reset release
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h12;
        reset = 1'b1;
        tick();
        check_eq("first_edge_no_gnt", gnt0, 0);
        tick();
        check_eq("rd_gnt0", gnt0, 1);
        check_eq("rd_gnt1", gnt1, 0);
        check_eq("rd_mem_addr", mem_addr, 8'h12);
        check_eq("rd_mem_we", mem_we, 0);
        req0 = 1'b0;
        tick();
        check_eq("rd_gnt0_off", gnt0, 0);
        check_eq("rd_rvalid0", rvalid0, 1);
        check_eq("rd_rvalid1", rvalid1, 0);
        check_eq("rd_rdata", rdata, 8'hA5);
        tick();
        check_eq("rd_rvalid0_off", rvalid0, 0);

        // Contention right after reset: 0,1,0,1,0,1
        apply_reset();
        req0 = 1'b1; addr0 = 8'h12;
        req1 = 1'b1; addr1 = 8'h20;
        tick();
        check_eq("cont_arm_no_gnt", gnt0 | gnt1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("cont_gnt0", gnt0, (i % 2) == 0);
            check_eq("cont_gnt1", gnt1, (i % 2) == 1);
            if (i > 0) begin
                check_eq("cont_rvalid0", rvalid0, ((i - 1) % 2) == 0);
                check_eq("cont_rdata", rdata, (((i - 1) % 2) == 0) ? 8'hA5 : 8'h5A);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_eq("cont_tail_rvalid1", rvalid1, 1);
        check_eq("cont_tail_rdata", rdata, 8'h5A);
        check_eq("cont_tail_gnt", gnt0 | gnt1, 0);

        // Write then read by requester 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 8'h3C;
        tick();
        check_eq("wr_gnt1", gnt1, 1);
        check_eq("wr_mem_we", mem_we, 1);
        check_eq("wr_mem_addr", mem_addr, 8'h40);
        check_eq("wr_mem_wdata", mem_wdata, 8'h3C);
        we1 = 1'b0;
        tick();
        check_eq("rb_gnt1", gnt1, 1);
        check_eq("rb_mem_we", mem_we, 0);
        req1 = 1'b0;
        tick();
        check_eq("rb_rvalid1", rvalid1, 1);
        check_eq("rb_rdata", rdata, 8'h3C);
        check_eq("rb_mem_we_idle", mem_we, 0);
        check_eq("rb_rvalid0", rvalid0, 0);

        // Locked sequence: req0 three accesses lock 1,1,0 while req1 waits
        if (c_lk) begin
            seq_g0 = 5'b00111; seq_g1 = 5'b01000;
        end else begin
            seq_g0 = 5'b01101; seq_g1 = 5'b00010;
        end
        left0 = 3;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h12; lock0 = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20; lock1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("lockseq_gnt0", gnt0, seq_g0[i]);
            check_eq("lockseq_gnt1", gnt1, seq_g1[i]);
            if (gnt0) begin
                left0 = left0 - 1;
                lock0 = (left0 >= 2);
                if (left0 == 0) req0 = 1'b0;
            end
            if (gnt1) req1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        tick();

        // Lock timeout: owner drops its request, other side waits
        req0 = 1'b1; addr0 = 8'h12; lock0 = 1'b1;
        tick();
        check_eq("to_gnt0", gnt0, 1);
        req0 = 1'b0; lock0 = 1'b0;
        req1 = 1'b1; addr1 = 8'h20;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check_eq("to_gnt1", gnt1, c_lk ? (i == 17) : (i == 1));
            check_eq("to_lock_err", lock_err, c_lk ? (i == 16) : 0);
            check_eq("to_gnt0_idle", gnt0, 0);
            if (gnt1) req1 = 1'b0;
        end
        tick();
        tick();

        // Reset asserted during a read access
        req0 = 1'b1; addr0 = 8'h12;
        tick();
        check_eq("rr_gnt0", gnt0, 1);
        req0 = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rr_async_gnt0", gnt0, 0);
        check_eq("rr_async_addr", mem_addr, 0);
        tick();
        check_eq("rr_rvalid0", rvalid0, 0);
        check_eq("rr_outs", {gnt0, gnt1, rvalid1, mem_we, lock_err}, 0);
        tick();
        reset = 1'b1;
        req0 = 1'b1;
        tick();
        check_eq("rr_rel_rvalid0", rvalid0, 0);
        check_eq("rr_rel_gnt0", gnt0, 0);
        tick();
        check_eq("rr_again_gnt0", gnt0, 1);
        req0 = 1'b0;
        tick();
        check_eq("rr_again_rvalid0", rvalid0, 1);
        check_eq("rr_again_rdata", rdata, 8'hA5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grid_arbiter.md
GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: grid memory address width.
REQ-002 Parameter DATA_W, default 8: grid memory data width.
REQ-003 Parameter LOCK_MAX, default 16: maximum number of cycles a locked owner holds the port before forced release.
REQ-004 Port clk  in  1: single clock, all logic on rising edge.
REQ-005 Port reset  in  1: asynchronous, active-low reset; asserted when 0.
REQ-006 Ports req0/req1  in  1 each: access request from requester 0 (piece logic) and requester 1 (line-clear engine).
REQ-007 Ports we0/we1  in  1 each: 1 = write, 0 = read, qualified by reqN.
REQ-008 Ports addr0/addr1  in  ADDR_W each: access address.
REQ-009 Ports wdata0/wdata1  in  DATA_W each: write data.
REQ-010 Ports lock0/lock1  in  1 each: keep ownership after this access.
REQ-011 Ports gnt0/gnt1  out  1 each: one-cycle pulse, access issued to memory this cycle.
REQ-012 Ports rvalid0/rvalid1  out  1 each: one-cycle pulse, rdata holds the read result.
REQ-013 Port rdata  out  DATA_W: read data, a direct pass-through of mem_q.
REQ-014 Ports mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_we  out  1: registered drive to grid memory port A.
REQ-015 Port mem_q  in  DATA_W: port A read data, one cycle after mem_addr.
REQ-016 Port lock_err  out  1: one-cycle pulse on forced lock release.

Function
REQ-017 A requester SHALL hold reqN, weN, addrN, wdataN and lockN stable from assertion until the cycle gntN is sampled high.
REQ-018 The arbiter SHALL sample requests on clock edge k; the winner's mem_addr, mem_wdata and mem_we and its gntN SHALL be valid in cycle k+1.
REQ-019 For a read granted in cycle k+1, rvalidN SHALL pulse in cycle k+2, with rdata = mem_q.
REQ-020 mem_we SHALL be 0 in every cycle without a grant; gnt0 and gnt1 SHALL never be high together.
REQ-021 Sustained throughput SHALL be one access per cycle; back-to-back grants to the same requester are allowed.
REQ-022 FSM states SHALL be ARB, OWN0 and OWN1.
REQ-023 In ARB with exactly one request, that requester wins.
REQ-024 In ARB with both requesting, the requester not granted most recently wins (round-robin pointer); the pointer updates on every grant.
REQ-025 A win with lockN=1 SHALL move the FSM to OWNN; a win with lockN=0 SHALL keep it in ARB.
REQ-026 In OWNN only requester N is served; requests from the other requester SHALL wait, with no grant and no loss of their request.
REQ-027 In OWNN, a grant with lockN=0 SHALL return the FSM to ARB after that access.
REQ-028 An OWNN cycle counter SHALL reset on entry; when it reaches LOCK_MAX without release, the FSM SHALL go to ARB, lock_err SHALL pulse, and the round-robin pointer SHALL favor the other requester.
REQ-029 In OWNN, a cycle with reqN=0 SHALL issue no access but SHALL still increment the counter.

Reset
REQ-030 While reset=0: FSM=ARB, pointer favors requester 0, lock counter=0; gnt0, gnt1, rvalid0, rvalid1, mem_we and lock_err = 0; mem_addr and mem_wdata = 0.
REQ-031 Reset asserted mid-access SHALL discard the pending access and any outstanding rvalid, with no late pulse after release.
REQ-032 The first grant can occur no earlier than the second rising edge after reset deassertion.

Configuration
REQ-033 With macro GRID_ARB_LOCK_EN defined: lock0, lock1, OWN0/OWN1, the lock counter and lock_err SHALL behave as in REQ-025 to REQ-029.
REQ-034 Without GRID_ARB_LOCK_EN: the lock inputs SHALL be ignored, the FSM SHALL remain in ARB permanently, lock_err SHALL be tied to 0, and no counter logic SHALL be built.

Verification
REQ-035 Single read: req0=1, we0=0, addr0=0x12, memory[0x12]=0xA5 -> gnt0 pulses 1 cycle after sampling; rvalid0 pulses the next cycle with rdata=0xA5.
REQ-036 Contention: req0 and req1 held high for 6 cycles after reset -> grant order 0,1,0,1,0,1; gnt never overlaps.
REQ-037 Write/read: req1 writes 0x3C to 0x40, then reads 0x40 -> mem_we=1 in exactly one cycle; the read returns rvalid1 with rdata=0x3C.
REQ-038 Locked sequence (GRID_ARB_LOCK_EN): req0 issues 3 accesses with lock0=1,1,0 while req1 stays high -> gnt0 x3 consecutive, then gnt1.
REQ-039 Lock timeout (LOCK_MAX=16): req0 granted with lock0=1, then req0 dropped -> after 16 cycles, lock_err pulses once and pending req1 is granted next.
REQ-040 Reset mid-read: reset=0 in the cycle after gnt0 -> no rvalid0 pulse, all outputs 0, then a normal grant after release.
